mesh_port_arbiter: RTL and testbench

//  Round-robin arbiter that shares one mesh router output port among N_IN input FIFOs
//   (4 neighbours + local terminal). Uses the mesh pndng/pop handshake on both sides.

---
 rtl/mesh_arb_pkg.sv | 18 +
 rtl/mesh_rr_picker.sv | 43 ++++
 rtl/mesh_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mesh_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared state type, watchdog width and round-robin pointer helper for the
// mesh output-port arbiter.
package mesh_arb_pkg;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_t;

   localparam int DEF_TIMEOUT = 50;
   localparam int STALL_CNT_W = $clog2(DEF_TIMEOUT + 1);

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      if (ptr >= n - 32'd1) begin
         return 32'd0;
      end else begin
         return ptr + 32'd1;
      end
   endfunction

endpackage

// File: rtl/mesh_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_IN. Holds no state.
module mesh_rr_picker #(
   parameter int N_IN = 5,
   parameter int ID_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] idx,
   output logic [N_IN-1:0] onehot
);

   int unsigned w_pos;

   // Priority search starting at ptr; the first hit locks the result.
   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      w_pos  = 32'd0;
      for (int k = 0; k < N_IN; k++) begin
         w_pos = 32'(ptr) + 32'(k);
         if (w_pos >= 32'(N_IN)) begin
            w_pos = w_pos - 32'(N_IN);
         end else begin
            w_pos = w_pos;
         end
         if (!any && req[w_pos[ID_W-1:0]]) begin
            any = 1'b1;
            idx = w_pos[ID_W-1:0];
         end else begin
            any = any;
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end else begin
         onehot = '0;
      end
   end

endmodule

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter sharing one mesh output port among N_IN source FIFOs via a
// 1-entry holding register. Optional per-source grant counters: MESH_ARB_STATS_EN.
module mesh_port_arbiter
   import mesh_arb_pkg::*;
#(
   parameter int N_IN    = 5,
   parameter int pckg_sz = 40,
   parameter int TIMEOUT = 50
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_IN-1:0]           pndng_in,
   input  logic [N_IN*pckg_sz-1:0]   data_in,
   output logic [N_IN-1:0]           pop_in,
   output logic                      pndng_out,
   output logic [pckg_sz-1:0]        data_out,
   input  logic                      pop_out,
   output logic [$clog2(N_IN)-1:0]   grant_id,
   output logic                      stall
`ifdef MESH_ARB_STATS_EN
   ,
   output logic [N_IN*16-1:0]        grant_cnt
`endif
);

   localparam int ID_W  = $clog2(N_IN);
   localparam int CNT_W = (TIMEOUT <= DEF_TIMEOUT) ? STALL_CNT_W : $clog2(TIMEOUT + 1);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_grant_id;
   logic [ID_W-1:0]    w_idx;
   logic [pckg_sz-1:0] r_data;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   w_stall_cnt_nxt;
   logic               r_stall;
   logic               w_any;
   logic               w_can_grant;
   logic               w_grant;
   logic [N_IN-1:0]    w_onehot;

   mesh_rr_picker #(
      .N_IN (N_IN),
      .ID_W (ID_W)
   ) u_picker (
      .req    (pndng_in),
      .ptr    (r_rr_ptr),
      .any    (w_any),
      .idx    (w_idx),
      .onehot (w_onehot)
   );

   // The holding slot frees up either because it is empty or because it drains this cycle.
   assign w_can_grant = (r_state == EMPTY) | pop_out;
   assign w_grant     = w_can_grant & w_any & reset;
   assign pop_in      = {N_IN{w_grant}} & w_onehot;

   assign pndng_out = (r_state == FULL);
   assign data_out  = r_data;
   assign grant_id  = r_grant_id;
   assign stall     = r_stall;

   // Next holding-register state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: begin
            if (w_grant) begin
               w_state_nxt = FULL;
            end else begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop_out && !w_grant) begin
               w_state_nxt = EMPTY;
            end else begin
               w_state_nxt = FULL;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Watchdog count of consecutive cycles the downstream leaves a packet unconsumed.
   always_comb begin
      w_stall_cnt_nxt = '0;
      if ((r_state == FULL) && !pop_out) begin
         if (r_stall_cnt >= CNT_W'(TIMEOUT)) begin
            w_stall_cnt_nxt = CNT_W'(TIMEOUT);
         end else begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
         end
      end else begin
         w_stall_cnt_nxt = '0;
      end
   end

   // State register and watchdog; a reset drops any held packet.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= EMPTY;
         r_stall_cnt <= '0;
         r_stall     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         r_stall     <= r_stall | (w_stall_cnt_nxt == CNT_W'(TIMEOUT));
      end
   end

   // Capture the winning packet and advance the round-robin pointer past the winner.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data     <= '0;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
      end else if (w_grant) begin
         r_data     <= data_in[32'(w_idx)*pckg_sz +: pckg_sz];
         r_grant_id <= w_idx;
         r_rr_ptr   <= ID_W'(rr_next(32'(w_idx), 32'(N_IN)));
      end else begin
         r_data     <= r_data;
         r_grant_id <= r_grant_id;
         r_rr_ptr   <= r_rr_ptr;
      end
   end

`ifdef MESH_ARB_STATS_EN
   logic [N_IN*16-1:0] r_grant_cnt;

   // Per-source grant counters, wrapping at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_grant_cnt <= '0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            if (w_grant && w_onehot[i]) begin
               r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
            end else begin
               r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16];
            end
         end
      end
   end

   assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Self-checking bench for mesh_port_arbiter: a behavioural model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_mesh_port_arbiter;

   localparam int N  = 5;
   localparam int PW = 40;
   localparam int TO = 50;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    pndng_in = '0;
   logic [N*PW-1:0] data_in = '0;
   logic [N-1:0]    pop_in;
   logic            pndng_out;
   logic [PW-1:0]   data_out;
   logic            pop_out = 1'b0;
   logic [2:0]      grant_id;
   logic            stall;
`ifdef MESH_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mesh_port_arbiter #(.N_IN(N), .pckg_sz(PW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .pndng_in  (pndng_in),
      .data_in   (data_in),
      .pop_in    (pop_in),
      .pndng_out (pndng_out),
      .data_out  (data_out),
      .pop_out   (pop_out),
      .grant_id  (grant_id),
      .stall     (stall)
`ifdef MESH_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model state: what the holding register, pointer and watchdog must contain.
   bit          m_full  = 1'b0;
   logic [PW-1:0] m_data = '0;
   int          m_id    = 0;
   int          m_rr    = 0;
   int          m_cnt   = 0;
   bit          m_stall = 1'b0;
   int          m_gcnt [N];
   int          m_grants [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int m_winner(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] m_pop();
      int w;
      logic [N-1:0] r;
      r = '0;
      w = m_winner(pndng_in, m_rr);
      if (reset && (!m_full || pop_out) && w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge reset) begin
      int w;
      if (!reset) begin
         m_full = 1'b0; m_data = '0; m_id = 0; m_rr = 0; m_cnt = 0; m_stall = 1'b0;
         for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      end else begin
         w = m_winner(pndng_in, m_rr);
         if (m_full && !pop_out) begin
            if (m_cnt < TO) m_cnt = m_cnt + 1;
         end else begin
            m_cnt = 0;
         end
         if (m_cnt == TO) m_stall = 1'b1;
         if ((!m_full || pop_out) && w >= 0) begin
            m_data = data_in[w*PW +: PW];
            m_id   = w;
            m_rr   = (w + 1) % N;
            m_full = 1'b1;
            m_gcnt[w] = (m_gcnt[w] + 1) % 65536;
            m_grants.push_back(w);
         end else if (pop_out) begin
            m_full = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      chk("pop_in", 64'(pop_in), 64'(m_pop()));
      chk("pndng_out", 64'(pndng_out), 64'(m_full));
      chk("data_out", 64'(data_out), 64'(m_data));
      chk("grant_id", 64'(grant_id), 64'(m_id));
      chk("stall", 64'(stall), 64'(m_stall));
`ifdef MESH_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
`endif
   end

   task automatic drive(input logic [N-1:0] p, input logic po);
      @(posedge clk);
      #1;
      pndng_in = p;
      pop_out  = po;
      #3;
   endtask

   int seq [6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      logic [N-1:0] oh;
      pndng_in = 5'b11111;
      #3;
      chk("rst_pop_in", 64'(pop_in), 64'd0);
      chk("rst_pndng_out", 64'(pndng_out), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_data_out", 64'(data_out), 64'd0);
      pndng_in = 5'b00000;
      #7;
      reset = 1'b1;

      // Idle after reset.
      for (int k = 0; k < 2; k++) begin
         drive(5'b00000, 1'b0);
         chk("idle_pop_in", 64'(pop_in), 64'd0);
         chk("idle_pndng_out", 64'(pndng_out), 64'd0);
         chk("idle_stall", 64'(stall), 64'd0);
      end

      // All sources requesting, downstream always ready.
      for (int i = 0; i < N; i++) data_in[i*PW +: PW] = 40'h100 + 40'(i);
      for (int k = 0; k < 6; k++) begin
         drive(5'b11111, 1'b1);
         oh = 5'b00001 << seq[k];
         chk("rr_pop_in", 64'(pop_in), 64'(oh));
         if (k > 0) chk("rr_pndng_out", 64'(pndng_out), 64'd1);
      end
      drive(5'b00000, 1'b1);
      drive(5'b00000, 1'b0);
      chk("drain_pndng_out", 64'(pndng_out), 64'd0);
      chk("model_nseq", 64'(m_grants.size()), 64'd6);
      for (int k = 0; k < 6; k++) chk("model_seq", 64'(m_grants[k]), 64'(seq[k]));

      // Single request, downstream not ready.
      data_in[2*PW +: PW] = 40'hA5;
      drive(5'b00100, 1'b0);
      chk("single_pop_in", 64'(pop_in), 64'b00100);
      drive(5'b00001, 1'b0);
      chk("full_pop_in", 64'(pop_in), 64'd0);
      chk("full_pndng_out", 64'(pndng_out), 64'd1);
      chk("full_data_out", 64'(data_out), 64'hA5);
      chk("full_grant_id", 64'(grant_id), 64'd2);
      drive(5'b00001, 1'b0);
      chk("full_hold_pop_in", 64'(pop_in), 64'd0);

      // Back-to-back: pop and grant in the same cycle.
      data_in[1*PW +: PW] = 40'h12_3456_789A;
      drive(5'b00010, 1'b1);
      chk("b2b_pop_in", 64'(pop_in), 64'b00010);
      chk("b2b_pndng_out", 64'(pndng_out), 64'd1);
      drive(5'b00000, 1'b0);
      chk("b2b_pndng_keep", 64'(pndng_out), 64'd1);
      chk("b2b_data_out", 64'(data_out), 64'h12_3456_789A);
      chk("b2b_grant_id", 64'(grant_id), 64'd1);

      // Watchdog: the cycle above is stalled cycle 1; stall rises after the 50th.
      for (int k = 2; k <= TO; k++) begin
         drive(5'b00000, 1'b0);
         if (k == TO) chk("stall_49", 64'(stall), 64'd0);
      end
      drive(5'b00000, 1'b1);
      chk("stall_50", 64'(stall), 64'd1);
      drive(5'b00000, 1'b0);
      chk("stall_sticky", 64'(stall), 64'd1);
      chk("stall_empty", 64'(pndng_out), 64'd0);
      drive(5'b00000, 1'b1);
      drive(5'b00000, 1'b0);
      chk("idle_pop_ignored", 64'(pndng_out), 64'd0);

      // Reset while FULL; rr pointer would be 1 without the reset.
      data_in[0*PW +: PW] = 40'hBEEF;
      drive(5'b00001, 1'b0);
      drive(5'b00000, 1'b0);
      chk("pre_rst_pndng_out", 64'(pndng_out), 64'd1);
`ifdef MESH_ARB_STATS_EN
      chk("pre_rst_cnt0", 64'(grant_cnt[0*16 +: 16]), 64'd3);
      chk("pre_rst_cnt1", 64'(grant_cnt[1*16 +: 16]), 64'd2);
      chk("pre_rst_cnt2", 64'(grant_cnt[2*16 +: 16]), 64'd2);
      chk("pre_rst_cnt4", 64'(grant_cnt[4*16 +: 16]), 64'd1);
`endif
      reset = 1'b0;
      #1;
      chk("mid_rst_pndng_out", 64'(pndng_out), 64'd0);
      chk("mid_rst_data_out", 64'(data_out), 64'd0);
      chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
      chk("mid_rst_stall", 64'(stall), 64'd0);
`ifdef MESH_ARB_STATS_EN
      chk("mid_rst_grant_cnt", 64'(grant_cnt[63:0]), 64'd0);
`endif
      @(posedge clk);
      #3;
      reset = 1'b1;
      drive(5'b11111, 1'b0);
      chk("post_rst_rr", 64'(pop_in), 64'b00001);
      drive(5'b00000, 1'b1);
      drive(5'b00000, 1'b0);
      chk("post_rst_empty", 64'(pndng_out), 64'd0);

      @(posedge clk);
      #7;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
